// File: rtl/des_pkg.sv
// DES key-schedule constants and permutations shared by the decrypt subkey generator.
// Bit numbering follows the port vectors: index 1 is the LSB, DES table entry n names the n-th bit from the MSB.
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    localparam int PC1_TAB [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Right-rotate amount applied before emitting the subkey for schedule step n.
    localparam int ROT_DEC [1:16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [56:1] pc1(input logic [64:1] k);
        logic [56:1] r;
        r = '0;
        for (int i = 1; i <= 56; i++) begin
            r[57 - i] = k[65 - PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [48:1] pc2(input logic [56:1] cd);
        logic [48:1] r;
        r = '0;
        for (int i = 1; i <= 48; i++) begin
            r[49 - i] = cd[57 - PC2_TAB[i]];
        end
        return r;
    endfunction

    // True when the step that follows `step` rotates by two; steps past the end report one.
    function automatic logic rot_next_is_two(input logic [4:0] step);
        logic r;
        r = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            if (int'(step) + 1 == i) r = (ROT_DEC[i] == 2);
        end
        return r;
    endfunction

endpackage

// File: rtl/des_rotr28.sv
// Combinational 28-bit right rotate of one key half by one or two positions.
module des_rotr28 (
    input  logic [28:1] x_i,
    input  logic        two_i,
    output logic [28:1] y_o
);

    assign y_o = two_i ? {x_i[2:1], x_i[28:3]} : {x_i[1], x_i[28:2]};

endmodule

// File: rtl/des_subkey_gen_dec.sv
// Sequential DES decryption key schedule: emits K16 down to K1, one per valid/ready handshake.
// C/D halves rotate right so the schedule walks the encryption schedule backwards.
module des_subkey_gen_dec
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = DES_ROUNDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [64:1] key,
    output logic [48:1] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [4:1]  round_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_STEP = 5'(NUM_ROUNDS);

    state_e      state_q, state_d;
    logic [4:0]  step_q, step_d;
    logic [28:1] c_q, c_d, d_q, d_d;
    logic [48:1] subkey_q, subkey_d;
    logic [3:0]  round_q, round_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [56:1] key_pc1;
    logic        rot_two;
    logic [28:1] c_rot, d_rot;

    assign key_pc1 = pc1(key);
    assign rot_two = rot_next_is_two(step_q);

    des_rotr28 u_rotr_c (.x_i(c_q), .two_i(rot_two), .y_o(c_rot));
    des_rotr28 u_rotr_d (.x_i(d_q), .two_i(rot_two), .y_o(d_rot));

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        step_d   = step_q;
        c_d      = c_q;
        d_d      = d_q;
        subkey_d = subkey_q;
        round_d  = round_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    c_d      = key_pc1[56:29];
                    d_d      = key_pc1[28:1];
                    subkey_d = pc2(key_pc1);
                    round_d  = 4'd0;  // round 16 wraps to 0 in four bits
                    step_d   = 5'd1;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = S_EMIT;
                end
            end
            S_EMIT: begin
                if (valid_q && subkey_ready) begin
                    if (step_q == LAST_STEP) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        step_d   = step_q + 5'd1;
                        c_d      = c_rot;
                        d_d      = d_rot;
                        subkey_d = pc2({c_rot, d_rot});
                        round_d  = round_q - 4'd1;
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            c_q      <= '0;
            d_q      <= '0;
            subkey_q <= '0;
            round_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            c_q      <= c_d;
            d_q      <= d_d;
            subkey_q <= subkey_d;
            round_q  <= round_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign subkey       = subkey_q;
    assign subkey_valid = valid_q;
    assign round_idx    = round_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_subkey_gen_dec.sv
// Directed bench for des_subkey_gen_dec: a forward (left-rotate) software key schedule fills a
// scoreboard in reverse order, and each accepted subkey is popped and compared.
module tb_des_subkey_gen_dec;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY_C = 64'hFEDCBA9876543210;

    localparam int PC1_T [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int LS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [64:1] key;
    logic [48:1] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [4:1]  round_idx;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    logic [52:1] sb[$];
    logic [56:1] exp_cd;
    logic [48:1] first_key, last_key;
    logic [3:0]  first_round, last_round;
    logic [56:1] cd_at_done;

    des_subkey_gen_dec #(.NUM_ROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key          (key),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Forward encryption schedule K1..K16 with left rotations; pushed K16 first.
    task automatic model_push(input logic [64:1] k);
        bit          kb [1:64];
        bit          c [1:28];
        bit          d [1:28];
        bit          tc, td;
        logic [48:1] ks [1:16];
        int          p;
        for (int n = 1; n <= 64; n++) kb[n] = k[65 - n];
        for (int i = 1; i <= 28; i++) begin
            c[i] = kb[PC1_T[i]];
            d[i] = kb[PC1_T[i + 28]];
        end
        for (int r = 1; r <= 16; r++) begin
            for (int s = 0; s < LS[r]; s++) begin
                tc = c[1];
                td = d[1];
                for (int j = 1; j <= 27; j++) begin
                    c[j] = c[j + 1];
                    d[j] = d[j + 1];
                end
                c[28] = tc;
                d[28] = td;
            end
            if (r == 1) begin
                for (int i = 1; i <= 28; i++) begin
                    exp_cd[57 - i] = c[i];
                    exp_cd[29 - i] = d[i];
                end
            end
            for (int j = 1; j <= 48; j++) begin
                p = PC2_T[j];
                ks[r][49 - j] = (p <= 28) ? c[p] : d[p - 28];
            end
        end
        for (int r = 16; r >= 1; r--) sb.push_back({4'(r), ks[r]});
    endtask

    // One full schedule from an IDLE negedge; returns at the IDLE negedge after FIN.
    task automatic run_keys(input logic [64:1] k, input int stall_round, input int inject_round,
                            input logic [64:1] inject_key, input bit poke_fin);
        logic [52:1] exp_e;
        int          valid_cycles = 0;
        int          stall_left;
        bit          done_now = 1'b0;
        bit          injected = 1'b0;
        bit          gap = 1'b0;
        bit          first = 1'b1;
        sb.delete();
        model_push(k);
        stall_left   = (stall_round >= 0) ? 5 : 0;
        start        = 1'b1;
        key          = k;
        subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = ~k;
        check("first_valid", 64'(subkey_valid), 64'd1);
        check("first_busy", 64'(busy), 64'd1);
        for (int cyc = 0; cyc < 80 && !done_now; cyc++) begin
            start = 1'b0;
            if (subkey_valid) begin
                valid_cycles++;
                if (first) begin
                    first_key   = subkey;
                    first_round = round_idx;
                    first       = 1'b0;
                end
                if (int'(round_idx) == stall_round && stall_left > 0) begin
                    subkey_ready = 1'b0;
                    stall_left--;
                    check("stall_hold", 64'({round_idx, subkey}), 64'(sb[0]));
                end else begin
                    subkey_ready = 1'b1;
                    last_key     = subkey;
                    last_round   = round_idx;
                    if (sb.size() > 0) begin
                        exp_e = sb.pop_front();
                        check("subkey", 64'({round_idx, subkey}), 64'(exp_e));
                    end else begin
                        check("extra_subkey", 64'(round_idx), 64'hFF);
                    end
                end
                if (int'(round_idx) == inject_round && !injected) begin
                    start    = 1'b1;
                    key      = inject_key;
                    injected = 1'b1;
                end
            end else if (!done) begin
                gap = 1'b1;
            end
            if (done) done_now = 1'b1;
            else @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 64'(done_now), 64'd1);
        check("no_valid_gap", 64'(gap), 64'd0);
        check("valid_cycles", 64'(valid_cycles), 64'(16 + ((stall_round >= 0) ? 5 : 0)));
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("done_valid_low", 64'(subkey_valid), 64'd0);
        check("done_busy_high", 64'(busy), 64'd1);
        cd_at_done = {dut.c_q, dut.d_q};
        check("cd_invariant", 64'(cd_at_done), 64'(exp_cd));
        if (poke_fin) begin
            start = 1'b1;
            key   = KEY_C;
        end
        @(negedge clk);
        start = 1'b0;
        check("idle_done_low", 64'(done), 64'd0);
        check("idle_busy_low", 64'(busy), 64'd0);
        check("idle_valid_low", 64'(subkey_valid), 64'd0);
    endtask

    initial begin
        bit reached = 1'b0;
        rst_n        = 1'b0;
        start        = 1'b0;
        key          = '0;
        subkey_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_round", 64'(round_idx), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain run with ready high; start during FIN must be ignored.
        run_keys(KEY_A, -1, -1, '0, 1'b1);
        check("k16_const", 64'(first_key), 64'hCB3D8B0E17F5);
        check("k16_round", 64'(first_round), 64'h0);
        check("k1_const", 64'(last_key), 64'h1B02EFFC7072);
        check("k1_round", 64'(last_round), 64'h1);
        check("cd_const", 64'(cd_at_done), 64'({28'hE19955F, 28'hAACCF1E}));

        // Stall at round 9, foreign start at round 12; then a back-to-back start from IDLE.
        run_keys(KEY_A, 9, 12, KEY_C, 1'b0);
        run_keys(KEY_C, -1, -1, '0, 1'b0);

        // Asynchronous reset mid-cycle at round 5.
        sb.delete();
        start        = 1'b1;
        key          = KEY_B;
        subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 40 && !reached; cyc++) begin
            if (subkey_valid && round_idx == 4'd5) reached = 1'b1;
            else @(negedge clk);
        end
        check("reach_round5", 64'(reached), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(subkey_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_subkey", 64'(subkey), 64'd0);
        check("arst_round", 64'(round_idx), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("arst_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_keys(KEY_B, -1, -1, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
